// File: rtl/ram_responder.sv
// Variable-latency word RAM: each request spends LAT cycles in BUSY, then one cycle in ACCESS.
// Reads return data registered on ACCESS entry. Writes commit on the edge that ends ACCESS.
module ram_responder #(
    parameter int LAT = 2,
    parameter int AW  = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int CW    = $clog2(LAT + 1);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            op_q;          // 1 = write, 0 = read
    logic [AW-1:0]   idx_q;
    logic [31:0]     load_q;
    logic [31:0]     mem [DEPTH];

    logic            req_none;
    logic            req_bad;
    logic            req_wr;
    logic            op_d;
    logic [AW-1:0]   idx_d;
    logic            same_req;
    logic            wr_en;
    logic            unused_addr_hi;

    assign req_none = !ramREN && !ramWEN;
    assign req_bad  = !req_none && ((ramREN && ramWEN) || (ramaddr[1:0] != 2'b00));
    assign req_wr   = !req_none && !req_bad && ramWEN;
    assign op_d     = ramWEN;
    assign idx_d    = ramaddr[AW+1:2];
    assign same_req = (op_d == op_q) && (idx_d == idx_q);

    // Upper address bits alias onto the same words.
    assign unused_addr_hi = ^ramaddr[31:AW+2];

    // The write only lands if the controller still presents the same write while in ACCESS.
    assign wr_en = !RST && (state_q == ACCESS) && op_q && req_wr && (idx_d == idx_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FREE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            load_q  <= '0;
        end else begin
            case (state_q)
                BUSY: begin
                    if (req_none) begin
                        state_q <= FREE;
                    end else if (req_bad) begin
                        state_q <= ERROR;
                    end else if (!same_req) begin
                        state_q <= BUSY;
                        op_q    <= op_d;
                        idx_q   <= idx_d;
                        cnt_q   <= CW'(LAT - 1);
                    end else if (cnt_q == '0) begin
                        state_q <= ACCESS;
                        if (!op_q) begin
                            load_q <= mem[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    // FREE, ACCESS and ERROR share one exit rule, so back-to-back requests need no FREE gap.
                    if (req_none) begin
                        state_q <= FREE;
                    end else if (req_bad) begin
                        state_q <= ERROR;
                    end else begin
                        state_q <= BUSY;
                        op_q    <= op_d;
                        idx_q   <= idx_d;
                        cnt_q   <= CW'(LAT - 1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[idx_q] <= ramstore;
        end
    end

    assign ramload  = load_q;
    assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (LAT=2, AW=10): a vector table plus hand-written multi-cycle sequences.
module tb_ram_responder;

    localparam logic [1:0] FR = 2'd0;
    localparam logic [1:0] BZ = 2'd1;
    localparam logic [1:0] AC = 2'd2;
    localparam logic [1:0] ER = 2'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ramREN = 1'b0;
    logic        ramWEN = 1'b0;
    logic [31:0] ramaddr = '0;
    logic [31:0] ramstore = '0;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [1:0]  exp_state;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];

    ram_responder #(.LAT(2), .AW(10)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ren, input logic wen,
                        input logic [31:0] a, input logic [31:0] d);
        RST      = rst;
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = a;
        ramstore = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] st, input logic [31:0] ld);
        vec_t v;
        v.rst = rst; v.ren = ren; v.wen = wen; v.addr = a; v.store = d;
        v.exp_state = st; v.exp_load = ld;
        vecs.push_back(v);
    endtask

    initial begin : main
        int busy_cnt;
        logic reached;

        // Reset: three cycles, idle inputs.
        add(1, 0, 0, 32'h0, 32'h0, FR, 32'h0);
        add(1, 0, 0, 32'h0, 32'h0, FR, 32'h0);
        add(1, 0, 0, 32'h0, 32'h0, FR, 32'h0);
        // Write 0x40, held through ACCESS, then read it back.
        add(0, 0, 1, 32'h40, 32'hDEADBEEF, BZ, 32'h0);
        add(0, 0, 1, 32'h40, 32'hDEADBEEF, BZ, 32'h0);
        add(0, 0, 1, 32'h40, 32'hDEADBEEF, AC, 32'h0);
        add(0, 0, 1, 32'h40, 32'hDEADBEEF, BZ, 32'h0);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'h0);
        add(0, 1, 0, 32'h40, 32'h0,        BZ, 32'h0);
        add(0, 1, 0, 32'h40, 32'h0,        BZ, 32'h0);
        add(0, 1, 0, 32'h40, 32'h0,        AC, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'hDEADBEEF);
        // Both enables, then misaligned read.
        add(0, 1, 1, 32'h40, 32'h0, ER, 32'hDEADBEEF);
        add(0, 1, 1, 32'h40, 32'h0, ER, 32'hDEADBEEF);
        add(0, 1, 1, 32'h40, 32'h0, ER, 32'hDEADBEEF);
        add(0, 1, 1, 32'h40, 32'h0, ER, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,  32'h0, FR, 32'hDEADBEEF);
        add(0, 1, 0, 32'h42, 32'h0, ER, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,  32'h0, FR, 32'hDEADBEEF);
        // Seed 0x44, then read 0x40 and retarget to 0x44 after one BUSY cycle.
        add(0, 0, 1, 32'h44, 32'h11112222, BZ, 32'hDEADBEEF);
        add(0, 0, 1, 32'h44, 32'h11112222, BZ, 32'hDEADBEEF);
        add(0, 0, 1, 32'h44, 32'h11112222, AC, 32'hDEADBEEF);
        add(0, 0, 1, 32'h44, 32'h11112222, BZ, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'hDEADBEEF);
        add(0, 1, 0, 32'h40, 32'h0,        BZ, 32'hDEADBEEF);
        add(0, 1, 0, 32'h44, 32'h0,        BZ, 32'hDEADBEEF);
        add(0, 1, 0, 32'h44, 32'h0,        BZ, 32'hDEADBEEF);
        add(0, 1, 0, 32'h44, 32'h0,        AC, 32'h11112222);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'h11112222);
        // Seed 0x80, then a write interrupted by reset in its second BUSY cycle.
        add(0, 0, 1, 32'h80, 32'hA5A5A5A5, BZ, 32'h11112222);
        add(0, 0, 1, 32'h80, 32'hA5A5A5A5, BZ, 32'h11112222);
        add(0, 0, 1, 32'h80, 32'hA5A5A5A5, AC, 32'h11112222);
        add(0, 0, 1, 32'h80, 32'hA5A5A5A5, BZ, 32'h11112222);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'h11112222);
        add(0, 0, 1, 32'h80, 32'h12345678, BZ, 32'h11112222);
        add(0, 0, 1, 32'h80, 32'h12345678, BZ, 32'h11112222);
        add(1, 0, 1, 32'h80, 32'h12345678, FR, 32'h0);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'h0);
        add(0, 1, 0, 32'h80, 32'h0,        BZ, 32'h0);
        add(0, 1, 0, 32'h80, 32'h0,        BZ, 32'h0);
        add(0, 1, 0, 32'h80, 32'h0,        AC, 32'hA5A5A5A5);
        add(0, 0, 0, 32'h0,  32'h0,        FR, 32'hA5A5A5A5);
        // Aliasing: write 0x10, read 0x1010 held through ACCESS.
        add(0, 0, 1, 32'h10,   32'hCAFEF00D, BZ, 32'hA5A5A5A5);
        add(0, 0, 1, 32'h10,   32'hCAFEF00D, BZ, 32'hA5A5A5A5);
        add(0, 0, 1, 32'h10,   32'hCAFEF00D, AC, 32'hA5A5A5A5);
        add(0, 0, 1, 32'h10,   32'hCAFEF00D, BZ, 32'hA5A5A5A5);
        add(0, 0, 0, 32'h0,    32'h0,        FR, 32'hA5A5A5A5);
        add(0, 1, 0, 32'h1010, 32'h0,        BZ, 32'hA5A5A5A5);
        add(0, 1, 0, 32'h1010, 32'h0,        BZ, 32'hA5A5A5A5);
        add(0, 1, 0, 32'h1010, 32'h0,        AC, 32'hCAFEF00D);
        add(0, 1, 0, 32'h1010, 32'h0,        BZ, 32'hCAFEF00D);
        add(0, 1, 0, 32'h1010, 32'h0,        BZ, 32'hCAFEF00D);
        add(0, 1, 0, 32'h1010, 32'h0,        AC, 32'hCAFEF00D);
        add(0, 0, 0, 32'h0,    32'h0,        FR, 32'hCAFEF00D);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].store);
            chk($sformatf("vec%0d_state", i), {30'd0, ramstate}, {30'd0, vecs[i].exp_state});
            chk($sformatf("vec%0d_load", i), ramload, vecs[i].exp_load);
        end

        // Write to 0x40 whose index changes during ACCESS must not land.
        step(0, 0, 1, 32'h40, 32'h0BADF00D);
        chk("drop_busy1", {30'd0, ramstate}, {30'd0, BZ});
        step(0, 0, 1, 32'h40, 32'h0BADF00D);
        chk("drop_busy2", {30'd0, ramstate}, {30'd0, BZ});
        step(0, 0, 1, 32'h40, 32'h0BADF00D);
        chk("drop_access", {30'd0, ramstate}, {30'd0, AC});
        step(0, 0, 1, 32'h44, 32'h0BADF00D);
        chk("drop_recapture", {30'd0, ramstate}, {30'd0, BZ});
        step(0, 0, 0, 32'h0, 32'h0);
        chk("drop_abort", {30'd0, ramstate}, {30'd0, FR});
        step(0, 1, 0, 32'h40, 32'h0);
        step(0, 1, 0, 32'h40, 32'h0);
        step(0, 1, 0, 32'h40, 32'h0);
        chk("drop_rd_state", {30'd0, ramstate}, {30'd0, AC});
        chk("drop_rd_load", ramload, 32'hDEADBEEF);
        step(0, 0, 0, 32'h0, 32'h0);

        // Stable read should spend exactly LAT cycles in BUSY.
        busy_cnt = 0;
        reached  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step(0, 1, 0, 32'h10, 32'h0);
            if (ramstate == AC) begin
                reached = 1'b1;
                break;
            end
            if (ramstate == BZ) busy_cnt++;
        end
        chk("lat_reached_access", {31'd0, reached}, 32'd1);
        chk("lat_busy_cycles", busy_cnt, 32'd2);
        chk("lat_load", ramload, 32'hCAFEF00D);
        step(0, 0, 0, 32'h0, 32'h0);
        chk("final_free", {30'd0, ramstate}, {30'd0, FR});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
